// File: rtl/rob_pkg.sv
// Shared widths, entry layout and entry constructor for the reorder buffer.
package rob_pkg;
  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB_IDX_W = 4;
  localparam int unsigned RRF_IDX_W = 5;
  localparam int unsigned ARF_IDX_W = 3;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic                 has_dest;
    logic [ARF_IDX_W-1:0] arch_idx;
    logic [RRF_IDX_W-1:0] rrf_idx;
  } rob_entry_t;

  // Freshly dispatched entry: valid, not yet completed.
  function automatic rob_entry_t rob_new_entry(input logic                 has_dest,
                                               input logic [ARF_IDX_W-1:0] arch_idx,
                                               input logic [RRF_IDX_W-1:0] rrf_idx);
    rob_entry_t e;
    e.valid    = 1'b1;
    e.done     = 1'b0;
    e.has_dest = has_dest;
    e.arch_idx = arch_idx;
    e.rrf_idx  = rrf_idx;
    return e;
  endfunction
endpackage

// File: rtl/rob_commit_sel.sv
// In-order retirement select for the two oldest reorder-buffer entries.
module rob_commit_sel
  import rob_pkg::*;
(
  input  rob_entry_t i_head_entry,
  input  rob_entry_t i_next_entry,
  output logic       o_retire1,
  output logic       o_retire2
);
  logic w_unused;

  assign o_retire1 = i_head_entry.valid & i_head_entry.done;
  assign o_retire2 = o_retire1 & i_next_entry.valid & i_next_entry.done;

  // Payload fields are consumed by the top, not by the selection itself.
  assign w_unused = ^{i_head_entry.has_dest, i_head_entry.arch_idx, i_head_entry.rrf_idx,
                      i_next_entry.has_dest, i_next_entry.arch_idx, i_next_entry.rrf_idx};
endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: dual dispatch, triple completion, in-order dual retirement
// with registered ARF commit outputs.
module reorder_buffer #(
  parameter  int unsigned ROB_DEPTH = rob_pkg::ROB_DEPTH,
  parameter  int unsigned RRF_IDX_W = rob_pkg::RRF_IDX_W,
  parameter  int unsigned ARF_IDX_W = rob_pkg::ARF_IDX_W,
  localparam int unsigned PTR_W     = $clog2(ROB_DEPTH),
  localparam int unsigned OCC_W     = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 dispatch_en1,
  input  logic                 dispatch_en2,
  input  logic                 dispatch_has_dest1,
  input  logic                 dispatch_has_dest2,
  input  logic [ARF_IDX_W-1:0] dispatch_arch_idx1,
  input  logic [ARF_IDX_W-1:0] dispatch_arch_idx2,
  input  logic [RRF_IDX_W-1:0] dispatch_rrf_idx1,
  input  logic [RRF_IDX_W-1:0] dispatch_rrf_idx2,
  output logic                 two_slots_available,
  output logic [PTR_W-1:0]     alloc_idx1,
  output logic [PTR_W-1:0]     alloc_idx2,
  input  logic                 complete1_en,
  input  logic [PTR_W-1:0]     complete1_idx,
  input  logic                 complete2_en,
  input  logic [PTR_W-1:0]     complete2_idx,
  input  logic                 complete3_en,
  input  logic [PTR_W-1:0]     complete3_idx,
  output logic                 rob_write_valid1,
  output logic                 rob_write_valid2,
  output logic [ARF_IDX_W-1:0] rob_write_index1,
  output logic [ARF_IDX_W-1:0] rob_write_index2,
  output logic [RRF_IDX_W-1:0] rob_rrf_read_idx1,
  output logic [RRF_IDX_W-1:0] rob_rrf_read_idx2,
  output logic [1:0]           retire_count,
  output logic                 empty
);
  import rob_pkg::*;

  rob_entry_t           r_rob [ROB_DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [OCC_W-1:0]     r_count;
  logic                 r_wr_valid1;
  logic                 r_wr_valid2;
  logic [ARF_IDX_W-1:0] r_wr_idx1;
  logic [ARF_IDX_W-1:0] r_wr_idx2;
  logic [RRF_IDX_W-1:0] r_rrf_idx1;
  logic [RRF_IDX_W-1:0] r_rrf_idx2;
  logic [1:0]           r_retire_count;

  logic [PTR_W-1:0] w_head_p1;
  logic [PTR_W-1:0] w_tail_p1;
  logic             w_two_slots;
  logic             w_acc1;
  logic             w_acc2;
  logic             w_retire1;
  logic             w_retire2;
  logic             w_wr1;
  logic             w_wr2;
  logic [1:0]       w_acc_cnt;
  logic [1:0]       w_ret_cnt;
  rob_entry_t       w_head_entry;
  rob_entry_t       w_next_entry;

  assign w_head_p1    = r_head + PTR_W'(1);
  assign w_tail_p1    = r_tail + PTR_W'(1);
  assign w_head_entry = r_rob[r_head];
  assign w_next_entry = r_rob[w_head_p1];

  // Space check uses only the registered count; same-cycle retirement gives no bypass.
  assign w_two_slots = (r_count <= OCC_W'(ROB_DEPTH - 2));
  assign w_acc1      = w_two_slots & dispatch_en1;
  assign w_acc2      = w_acc1 & dispatch_en2;
  assign w_acc_cnt   = 2'(w_acc1) + 2'(w_acc2);
  assign w_ret_cnt   = 2'(w_retire1) + 2'(w_retire2);
  assign w_wr1       = w_retire1 & w_head_entry.has_dest;
  assign w_wr2       = w_retire2 & w_next_entry.has_dest;

  rob_commit_sel u_commit_sel (
    .i_head_entry (w_head_entry),
    .i_next_entry (w_next_entry),
    .o_retire1    (w_retire1),
    .o_retire2    (w_retire2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rob          <= '{default: '0};
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_wr_valid1    <= 1'b0;
      r_wr_valid2    <= 1'b0;
      r_wr_idx1      <= '0;
      r_wr_idx2      <= '0;
      r_rrf_idx1     <= '0;
      r_rrf_idx2     <= '0;
      r_retire_count <= '0;
    end else if (flush) begin
      r_rob          <= '{default: '0};
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_wr_valid1    <= 1'b0;
      r_wr_valid2    <= 1'b0;
      r_wr_idx1      <= '0;
      r_wr_idx2      <= '0;
      r_rrf_idx1     <= '0;
      r_rrf_idx2     <= '0;
      r_retire_count <= '0;
    end else if (stall) begin
      // Frozen: commit payload holds, but nothing re-fires.
      r_wr_valid1    <= 1'b0;
      r_wr_valid2    <= 1'b0;
      r_retire_count <= '0;
    end else begin
      if (complete1_en && r_rob[complete1_idx].valid) r_rob[complete1_idx].done <= 1'b1;
      if (complete2_en && r_rob[complete2_idx].valid) r_rob[complete2_idx].done <= 1'b1;
      if (complete3_en && r_rob[complete3_idx].valid) r_rob[complete3_idx].done <= 1'b1;
      if (w_retire1) r_rob[r_head]    <= '0;
      if (w_retire2) r_rob[w_head_p1] <= '0;
      if (w_acc1) r_rob[r_tail] <= rob_new_entry(dispatch_has_dest1, dispatch_arch_idx1,
                                                 dispatch_rrf_idx1);
      if (w_acc2) r_rob[w_tail_p1] <= rob_new_entry(dispatch_has_dest2, dispatch_arch_idx2,
                                                    dispatch_rrf_idx2);
      r_head         <= r_head + PTR_W'(w_ret_cnt);
      r_tail         <= r_tail + PTR_W'(w_acc_cnt);
      r_count        <= r_count + OCC_W'(w_acc_cnt) - OCC_W'(w_ret_cnt);
      r_wr_valid1    <= w_wr1;
      r_wr_valid2    <= w_wr2;
      r_wr_idx1      <= w_wr1 ? w_head_entry.arch_idx : '0;
      r_wr_idx2      <= w_wr2 ? w_next_entry.arch_idx : '0;
      r_rrf_idx1     <= w_wr1 ? w_head_entry.rrf_idx : '0;
      r_rrf_idx2     <= w_wr2 ? w_next_entry.rrf_idx : '0;
      r_retire_count <= w_ret_cnt;
    end
  end

  assign two_slots_available = w_two_slots;
  assign alloc_idx1          = r_tail;
  assign alloc_idx2          = w_tail_p1;
  assign rob_write_valid1    = r_wr_valid1;
  assign rob_write_valid2    = r_wr_valid2;
  assign rob_write_index1    = r_wr_idx1;
  assign rob_write_index2    = r_wr_idx2;
  assign rob_rrf_read_idx1   = r_rrf_idx1;
  assign rob_rrf_read_idx2   = r_rrf_idx2;
  assign retire_count        = r_retire_count;
  assign empty               = (r_count == '0);
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized bench for reorder_buffer against a program-order queue model,
// plus directed scenarios with literal expectations.
module tb_reorder_buffer;
  logic       clk;
  logic       rst_n;
  logic       stall;
  logic       flush;
  logic       dispatch_en1;
  logic       dispatch_en2;
  logic       dispatch_has_dest1;
  logic       dispatch_has_dest2;
  logic [2:0] dispatch_arch_idx1;
  logic [2:0] dispatch_arch_idx2;
  logic [4:0] dispatch_rrf_idx1;
  logic [4:0] dispatch_rrf_idx2;
  logic       two_slots_available;
  logic [3:0] alloc_idx1;
  logic [3:0] alloc_idx2;
  logic       complete1_en;
  logic [3:0] complete1_idx;
  logic       complete2_en;
  logic [3:0] complete2_idx;
  logic       complete3_en;
  logic [3:0] complete3_idx;
  logic       rob_write_valid1;
  logic       rob_write_valid2;
  logic [2:0] rob_write_index1;
  logic [2:0] rob_write_index2;
  logic [4:0] rob_rrf_read_idx1;
  logic [4:0] rob_rrf_read_idx2;
  logic [1:0] retire_count;
  logic       empty;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .dispatch_en1(dispatch_en1), .dispatch_en2(dispatch_en2),
    .dispatch_has_dest1(dispatch_has_dest1), .dispatch_has_dest2(dispatch_has_dest2),
    .dispatch_arch_idx1(dispatch_arch_idx1), .dispatch_arch_idx2(dispatch_arch_idx2),
    .dispatch_rrf_idx1(dispatch_rrf_idx1), .dispatch_rrf_idx2(dispatch_rrf_idx2),
    .two_slots_available(two_slots_available),
    .alloc_idx1(alloc_idx1), .alloc_idx2(alloc_idx2),
    .complete1_en(complete1_en), .complete1_idx(complete1_idx),
    .complete2_en(complete2_en), .complete2_idx(complete2_idx),
    .complete3_en(complete3_en), .complete3_idx(complete3_idx),
    .rob_write_valid1(rob_write_valid1), .rob_write_valid2(rob_write_valid2),
    .rob_write_index1(rob_write_index1), .rob_write_index2(rob_write_index2),
    .rob_rrf_read_idx1(rob_rrf_read_idx1), .rob_rrf_read_idx2(rob_rrf_read_idx2),
    .retire_count(retire_count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: in-flight instructions in program order, oldest first.
  typedef struct {
    int idx;
    bit hd;
    int arch;
    int tag;
    bit done;
  } ment_t;
  ment_t q[$];
  int m_tail = 0;
  int e_v1 = 0, e_v2 = 0, e_i1 = 0, e_i2 = 0, e_t1 = 0, e_t2 = 0, e_rc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_tail = 0;
    e_v1 = 0; e_v2 = 0; e_i1 = 0; e_i2 = 0; e_t1 = 0; e_t2 = 0; e_rc = 0;
  endfunction

  function automatic void mark_done(input logic en, input logic [3:0] idx);
    if (en) foreach (q[k]) if (q[k].idx == int'(idx)) q[k].done = 1'b1;
  endfunction

  // Expected effect of the coming clock edge given the inputs now applied.
  function automatic void model_step();
    int    cnt0;
    ment_t e;
    if (flush) begin
      model_reset();
      return;
    end
    if (stall) begin
      e_v1 = 0; e_v2 = 0; e_rc = 0;
      return;
    end
    cnt0 = q.size();
    e_v1 = 0; e_v2 = 0; e_i1 = 0; e_i2 = 0; e_t1 = 0; e_t2 = 0; e_rc = 0;
    if (q.size() > 0 && q[0].done) begin
      e = q.pop_front();
      e_rc = 1;
      if (e.hd) begin e_v1 = 1; e_i1 = e.arch; e_t1 = e.tag; end
      if (q.size() > 0 && q[0].done) begin
        e = q.pop_front();
        e_rc = 2;
        if (e.hd) begin e_v2 = 1; e_i2 = e.arch; e_t2 = e.tag; end
      end
    end
    mark_done(complete1_en, complete1_idx);
    mark_done(complete2_en, complete2_idx);
    mark_done(complete3_en, complete3_idx);
    if (cnt0 <= 14 && dispatch_en1) begin
      q.push_back('{idx: m_tail, hd: dispatch_has_dest1, arch: int'(dispatch_arch_idx1),
                    tag: int'(dispatch_rrf_idx1), done: 1'b0});
      m_tail = (m_tail + 1) % 16;
      if (dispatch_en2) begin
        q.push_back('{idx: m_tail, hd: dispatch_has_dest2, arch: int'(dispatch_arch_idx2),
                      tag: int'(dispatch_rrf_idx2), done: 1'b0});
        m_tail = (m_tail + 1) % 16;
      end
    end
  endfunction

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("write_valid1", int'(rob_write_valid1), e_v1);
      chk("write_valid2", int'(rob_write_valid2), e_v2);
      chk("write_index1", int'(rob_write_index1), e_i1);
      chk("write_index2", int'(rob_write_index2), e_i2);
      chk("rrf_tag1", int'(rob_rrf_read_idx1), e_t1);
      chk("rrf_tag2", int'(rob_rrf_read_idx2), e_t2);
      chk("retire_count", int'(retire_count), e_rc);
      chk("empty", int'(empty), (q.size() == 0) ? 1 : 0);
      chk("two_slots", int'(two_slots_available), (q.size() <= 14) ? 1 : 0);
      chk("alloc_idx1", int'(alloc_idx1), m_tail);
      chk("alloc_idx2", int'(alloc_idx2), (m_tail + 1) % 16);
    end
  end

  task automatic idle();
    stall = 1'b0; flush = 1'b0;
    dispatch_en1 = 1'b0; dispatch_en2 = 1'b0;
    dispatch_has_dest1 = 1'b0; dispatch_has_dest2 = 1'b0;
    dispatch_arch_idx1 = '0; dispatch_arch_idx2 = '0;
    dispatch_rrf_idx1 = '0; dispatch_rrf_idx2 = '0;
    complete1_en = 1'b0; complete2_en = 1'b0; complete3_en = 1'b0;
    complete1_idx = '0; complete2_idx = '0; complete3_idx = '0;
  endtask

  task automatic set_disp(input bit e1, input bit e2, input bit h1, input bit h2,
                          input int a1, input int a2, input int t1, input int t2);
    dispatch_en1 = e1; dispatch_en2 = e2;
    dispatch_has_dest1 = h1; dispatch_has_dest2 = h2;
    dispatch_arch_idx1 = 3'(a1); dispatch_arch_idx2 = 3'(a2);
    dispatch_rrf_idx1 = 5'(t1); dispatch_rrf_idx2 = 5'(t2);
  endtask

  task automatic set_cmp(input bit e1, input int i1, input bit e2, input int i2,
                         input bit e3, input int i3);
    complete1_en = e1; complete1_idx = 4'(i1);
    complete2_en = e2; complete2_idx = 4'(i2);
    complete3_en = e3; complete3_idx = 4'(i3);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_wv1"}, int'(rob_write_valid1), 0);
    chk({tag, "_wv2"}, int'(rob_write_valid2), 0);
    chk({tag, "_wi1"}, int'(rob_write_index1), 0);
    chk({tag, "_wi2"}, int'(rob_write_index2), 0);
    chk({tag, "_tag1"}, int'(rob_rrf_read_idx1), 0);
    chk({tag, "_tag2"}, int'(rob_rrf_read_idx2), 0);
    chk({tag, "_rc"}, int'(retire_count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_two"}, int'(two_slots_available), 1);
    chk({tag, "_alloc1"}, int'(alloc_idx1), 0);
  endtask

  function automatic logic [3:0] pick_idx();
    if (q.size() > 0 && $urandom_range(0, 3) != 0)
      return 4'(q[$urandom_range(0, q.size() - 1)].idx);
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic rand_cycle();
    stall = ($urandom_range(0, 99) < 10);
    flush = ($urandom_range(0, 999) < 20);
    set_disp($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    complete1_en = ($urandom_range(0, 99) < 60); complete1_idx = pick_idx();
    complete2_en = ($urandom_range(0, 99) < 40); complete2_idx = pick_idx();
    complete3_en = ($urandom_range(0, 99) < 25); complete3_idx = pick_idx();
    tick();
  endtask

  // Complete the oldest pending entries until the buffer empties (bounded).
  task automatic drain(input string tag);
    int n = 0;
    int c;
    while (q.size() != 0 && n < 200) begin
      idle();
      c = 0;
      for (int k = 0; k < q.size() && c < 3; k++) begin
        if (!q[k].done) begin
          case (c)
            0: begin complete1_en = 1'b1; complete1_idx = 4'(q[k].idx); end
            1: begin complete2_en = 1'b1; complete2_idx = 4'(q[k].idx); end
            default: begin complete3_en = 1'b1; complete3_idx = 4'(q[k].idx); end
          endcase
          c++;
        end
      end
      tick();
      n++;
    end
    idle();
    tick();
    tick();
    chk({tag, "_drained"}, int'(empty), 1);
  endtask

  int a;

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    reset_checks("por");
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Pair with destinations commits together two cycles after completion.
    a = m_tail;
    set_disp(1, 1, 1, 1, 3, 5, 7, 9); tick();
    idle(); set_cmp(1, a, 1, (a + 1) % 16, 0, 0); tick();
    idle(); tick();
    chk("pair_wv1", int'(rob_write_valid1), 1);
    chk("pair_wv2", int'(rob_write_valid2), 1);
    chk("pair_idx1", int'(rob_write_index1), 3);
    chk("pair_idx2", int'(rob_write_index2), 5);
    chk("pair_tag1", int'(rob_rrf_read_idx1), 7);
    chk("pair_tag2", int'(rob_rrf_read_idx2), 9);
    chk("pair_rc", int'(retire_count), 2);
    chk("pair_empty", int'(empty), 1);

    // Younger completes first: nothing commits until the older one is done.
    a = m_tail;
    set_disp(1, 1, 1, 1, 1, 2, 10, 11); tick();
    idle(); set_cmp(0, 0, 1, (a + 1) % 16, 0, 0); tick();
    idle(); tick(); tick();
    chk("ooo_rc", int'(retire_count), 0);
    chk("ooo_wv1", int'(rob_write_valid1), 0);
    chk("ooo_empty", int'(empty), 0);
    set_cmp(1, a, 0, 0, 0, 0); tick();
    idle(); tick();
    chk("ooo_rc2", int'(retire_count), 2);
    chk("ooo_idx1", int'(rob_write_index1), 1);
    chk("ooo_tag2", int'(rob_rrf_read_idx2), 11);

    // Stall holds a ready commit until released.
    a = m_tail;
    set_disp(1, 0, 1, 0, 4, 0, 12, 0); tick();
    idle(); set_cmp(1, a, 0, 0, 0, 0); tick();
    idle(); stall = 1'b1; tick(); tick();
    chk("stall_wv1", int'(rob_write_valid1), 0);
    chk("stall_rc", int'(retire_count), 0);
    stall = 1'b0; tick();
    chk("stall_rel_wv1", int'(rob_write_valid1), 1);
    chk("stall_rel_idx1", int'(rob_write_index1), 4);

    // Flush with stall squashes completed entries before they commit.
    a = m_tail;
    set_disp(1, 1, 1, 1, 6, 7, 14, 15); tick();
    idle(); set_cmp(1, a, 1, (a + 1) % 16, 0, 0); tick();
    idle(); stall = 1'b1; flush = 1'b1; tick();
    idle();
    chk("flush_empty", int'(empty), 1);
    chk("flush_wv1", int'(rob_write_valid1), 0);
    chk("flush_alloc1", int'(alloc_idx1), 0);
    repeat (3) tick();
    chk("flush_late_wv1", int'(rob_write_valid1), 0);

    // Fill to 16, refuse dispatch while full / at 15, then wrap.
    for (int i = 0; i < 8; i++) begin
      set_disp(1, 1, 1, 1, i % 8, (i + 1) % 8, 2 * i, 2 * i + 1);
      tick();
    end
    idle();
    chk("full_two", int'(two_slots_available), 0);
    chk("full_alloc1", int'(alloc_idx1), 0);
    set_disp(1, 1, 1, 1, 0, 0, 20, 21); tick();
    idle();
    chk("full_ignored_alloc1", int'(alloc_idx1), 0);
    set_cmp(1, 0, 0, 0, 0, 0); tick();
    idle(); tick();
    chk("at15_rc", int'(retire_count), 1);
    chk("at15_two", int'(two_slots_available), 0);
    set_cmp(1, 1, 0, 0, 0, 0); tick();
    idle(); tick();
    chk("at14_two", int'(two_slots_available), 1);
    set_disp(1, 1, 1, 1, 2, 3, 30, 31); tick();
    idle();
    chk("wrap_alloc1", int'(alloc_idx1), 2);
    drain("fill");

    // Entry without destination frees its slot silently.
    a = m_tail;
    set_disp(1, 0, 0, 0, 6, 0, 13, 0); tick();
    idle(); set_cmp(1, a, 0, 0, 0, 0); tick();
    idle(); tick();
    chk("nodest_rc", int'(retire_count), 1);
    chk("nodest_wv1", int'(rob_write_valid1), 0);
    chk("nodest_idx1", int'(rob_write_index1), 0);
    chk("nodest_empty", int'(empty), 1);

    repeat (1500) rand_cycle();

    // Asynchronous reset in the middle of traffic.
    idle();
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks("midrst_hold");
    rst_n = 1'b1;
    chk_en = 1'b1;

    set_disp(1, 0, 1, 0, 4, 0, 21, 0); tick();
    idle(); set_cmp(1, 0, 0, 0, 0, 0); tick();
    idle(); tick();
    chk("postrst_wv1", int'(rob_write_valid1), 1);
    chk("postrst_idx1", int'(rob_write_index1), 4);
    chk("postrst_tag1", int'(rob_rrf_read_idx1), 21);

    repeat (800) rand_cycle();
    drain("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
